alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, default 4, operand/result width in bits (legal 2..32).
REQ-002 Port: clock  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: in_valid  input  1  operand/control beat offered.
REQ-005 Port: in_ready  output  1  block accepts a beat this cycle.
REQ-006 Port: A  input  WIDTH  operand A.
REQ-007 Port: B  input  WIDTH  operand B.
REQ-008 Port: control  input  3  opcode.
REQ-009 Port: out_valid  output  1  result and flags valid.
REQ-010 Port: out_ready  input  1  consumer takes result this cycle.
REQ-011 Port: result  output  WIDTH  registered result.
REQ-012 Port: zero  output  1  result == 0.
REQ-013 Port: negative  output  1  result[WIDTH-1].
REQ-014 Port: carry  output  1  carry-out (ADD) / no-borrow (SUB), else 0.
REQ-015 Port: overflow  output  1  signed overflow (ADD/SUB), else 0.

Function
REQ-016 Opcodes SHALL be: 000 AND, 001 OR, 010 ADD, 011 SUB (A-B as A+~B+1), 100 XOR, 101 NOR, 110 SLT (signed A<B -> 1, else 0), 111 MUL (low WIDTH bits of unsigned A*B).
REQ-017 FSM SHALL have states IDLE, BUSY, DONE; in_ready = 1 only in IDLE.
REQ-018 A beat SHALL be accepted on a rising edge with in_valid & in_ready; A, B, control latched at that edge.
REQ-019 Ops 000-110: IDLE -> DONE on acceptance; result/flags registered at the acceptance edge; out_valid high the cycle after acceptance (latency 1).
REQ-020 MUL: IDLE -> BUSY on acceptance; shift-add, one multiplier bit per cycle, WIDTH cycles in BUSY; BUSY -> DONE at the edge completing iteration WIDTH; out_valid first high WIDTH+1 cycles after acceptance.
REQ-021 DONE: out_valid = 1; result and flags SHALL hold stable until out_ready sampled high; then DONE -> IDLE.
REQ-022 No new beat accepted in DONE even if out_ready is high that cycle (one-cycle IDLE bubble; max throughput one op per 2 cycles).
REQ-023 in_valid during BUSY/DONE SHALL be ignored; no operand corruption.
REQ-024 Arithmetic SHALL be WIDTH bits, wrap-around modulo 2^WIDTH; overflow = (sign A == sign B') & (sign result != sign A), B' = B or ~B.
REQ-025 zero and negative SHALL be valid for all opcodes; carry/overflow 0 for non-ADD/SUB.
REQ-026 MUL carry/overflow SHALL be 0; upper product bits discarded.

Reset
REQ-027 reset SHALL dominate all other inputs, including mid-BUSY or DONE.
REQ-028 After reset: state IDLE, in_ready 1, out_valid 0, result 0, zero 1, negative 0, carry 0, overflow 0, iteration counter 0.
REQ-029 A transaction interrupted by reset SHALL be discarded; no out_valid pulse.

Structure
REQ-030 Shared package alu_pkg SHALL hold the opcode constants and the FSM state enumeration.
REQ-031 Combinational single-cycle datapath SHALL be sub-module alu_core (WIDTH-parametrised: A, B, control -> result, carry, overflow); multiplier and FSM stay in alu_seq.
REQ-032 zero SHALL be a WIDTH-wide NOR reduction of the registered result.

Verification (WIDTH=4)
REQ-033 ADD 0111+0001 -> result 1000, overflow 1, negative 1, carry 0, zero 0, out_valid 1 cycle after accept.
REQ-034 SUB 0011-0011 -> result 0000, zero 1, carry 1; SLT 1110 vs 0001 -> result 0001.
REQ-035 MUL 0101*0011 -> result 1111, out_valid exactly 5 cycles after accept; in_ready 0 throughout.
REQ-036 Backpressure: out_ready low 3 cycles in DONE -> result/flags stable, in_ready 0; out_ready high -> IDLE next cycle.
REQ-037 reset asserted during cycle 2 of MUL -> next cycle IDLE, out_valid 0, zero 1; following AND 1100&1010 -> 1000.
REQ-038 in_valid held during BUSY with different operands -> ignored; MUL result unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings and FSM states.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOR = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Single-cycle combinational ALU datapath; MUL is handled by the sequential wrapper
// and yields zero here.
module alu_core import alu_pkg::*; #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       control,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow
);

  logic             sub;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum;
  logic             add_ovf;
  logic             slt;

  // SUB is A + ~B + 1, so the adder carry-out reads as "no borrow".
  assign sub     = (control == OP_SUB);
  assign b_op    = sub ? ~b : b;
  assign sum     = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub};
  assign add_ovf = (a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign slt     = $signed(a) < $signed(b);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    unique case (control)
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_ADD, OP_SUB: begin
        result   = sum[WIDTH-1:0];
        carry    = sum[WIDTH];
        overflow = add_ovf;
      end
      OP_XOR: result = a ^ b;
      OP_NOR: result = ~(a | b);
      OP_SLT: result = {{(WIDTH-1){1'b0}}, slt};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops finish in one cycle, MUL runs a WIDTH-cycle
// shift-add loop; the result is held in DONE until the consumer takes it.
module alu_seq import alu_pkg::*; #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state, state_next;
  logic             accept;
  logic             last_iter;

  logic [WIDTH-1:0] core_result;
  logic             core_carry;
  logic             core_overflow;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    count;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a        (A),
    .b        (B),
    .control  (control),
    .result   (core_result),
    .carry    (core_carry),
    .overflow (core_overflow)
  );

  assign accept    = in_valid && in_ready;
  assign last_iter = (count == LAST);
  assign acc_next  = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = (control == OP_MUL) ? BUSY : DONE;
      end
      BUSY: if (last_iter) state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Result and flags change only at acceptance (single-cycle ops) or on the
  // final multiply iteration, so they stay frozen while DONE waits.
  always_ff @(posedge clock) begin
    if (reset) begin
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      count    <= '0;
    end else if (accept) begin
      if (control == OP_MUL) begin
        mcand  <= A;
        mplier <= B;
        acc    <= '0;
        count  <= '0;
      end else begin
        result   <= core_result;
        carry    <= core_carry;
        overflow <= core_overflow;
      end
    end else if (state == BUSY) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (last_iter) begin
        count    <= '0;
        result   <= acc_next;
        carry    <= 1'b0;
        overflow <= 1'b0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

  assign zero     = ~|result;
  assign negative = result[WIDTH-1];

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=4): the driver pushes hand-computed
// expectations into a queue, and an independent monitor checks DUT output beats.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [2:0]   control;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         negative;
  logic         carry;
  logic         overflow;

  alu_seq #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .control   (control),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .negative  (negative),
    .carry     (carry),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    string        name;
    logic [W-1:0] res;
    logic [3:0]   flags;   // {zero, negative, carry, overflow}
    int           lat;
    int           acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   head_seen = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; the monitor samples on the falling edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 50 && !in_ready; i++) step();
    if (!in_ready) check({name, "_ready_timeout"}, in_ready, 1'b1);
  endtask

  task automatic send(input string name, input logic [2:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] res,
                      input logic [3:0] flags, input int lat);
    exp_t e;
    wait_ready(name);
    in_valid = 1'b1;
    A        = a;
    B        = b;
    control  = op;
    step();
    e.name    = name;
    e.res     = res;
    e.flags   = flags;
    e.lat     = lat;
    e.acc_cyc = cyc;
    sb.push_back(e);
    in_valid = 1'b0;
  endtask

  // Walk through BUSY until out_valid, checking in_ready stays low throughout.
  task automatic wait_done(input string name);
    int i;
    for (i = 0; i < 20; i++) begin
      check({name, "_in_ready_low"}, in_ready, 1'b0);
      if (out_valid) break;
      step();
    end
    if (!out_valid) check({name, "_done_timeout"}, out_valid, 1'b1);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (!reset && out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", out_valid, 1'b0);
      end else begin
        e = sb[0];
        if (!head_seen) begin
          check({e.name, "_latency"}, cyc - e.acc_cyc + 1, e.lat);
          head_seen = 1'b1;
        end
        check({e.name, "_result"}, result, e.res);
        check({e.name, "_flags"}, {zero, negative, carry, overflow}, e.flags);
        if (out_ready) begin
          void'(sb.pop_front());
          head_seen = 1'b0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    A         = '0;
    B         = '0;
    control   = OP_AND;
    out_ready = 1'b1;
    step();
    step();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, 4'b0000);
    check("rst_flags", {zero, negative, carry, overflow}, 4'b1000);
    reset = 1'b0;
    step();

    //   name          op      A        B        result   {z,n,c,v}  latency
    send("add_ovf",    OP_ADD, 4'b0111, 4'b0001, 4'b1000, 4'b0101, 1);
    send("sub_eq",     OP_SUB, 4'b0011, 4'b0011, 4'b0000, 4'b1010, 1);
    send("slt_neg",    OP_SLT, 4'b1110, 4'b0001, 4'b0001, 4'b0000, 1);
    send("and",        OP_AND, 4'b1100, 4'b1010, 4'b1000, 4'b0100, 1);
    send("or",         OP_OR,  4'b1100, 4'b0011, 4'b1111, 4'b0100, 1);
    send("xor",        OP_XOR, 4'b1010, 4'b0110, 4'b1100, 4'b0100, 1);
    send("nor",        OP_NOR, 4'b1010, 4'b0101, 4'b0000, 4'b1000, 1);
    send("add_wrap",   OP_ADD, 4'b1111, 4'b0001, 4'b0000, 4'b1010, 1);
    send("sub_borrow", OP_SUB, 4'b0000, 4'b0001, 4'b1111, 4'b0100, 1);
    send("sub_ovf",    OP_SUB, 4'b1000, 4'b0001, 4'b0111, 4'b0011, 1);
    send("slt_pos",    OP_SLT, 4'b0001, 4'b1110, 4'b0000, 4'b1000, 1);
    send("slt_equal",  OP_SLT, 4'b0011, 4'b0011, 4'b0000, 4'b1000, 1);

    send("mul_5x3",    OP_MUL, 4'b0101, 4'b0011, 4'b1111, 4'b0100, 5);
    wait_done("mul_5x3");
    send("mul_15x15",  OP_MUL, 4'b1111, 4'b1111, 4'b0001, 4'b0000, 5);
    wait_done("mul_15x15");

    // A beat offered during BUSY/DONE must not disturb the multiply.
    send("mul_hold",   OP_MUL, 4'b0110, 4'b0011, 4'b0010, 4'b0000, 5);
    in_valid = 1'b1;
    A        = 4'b1111;
    B        = 4'b1111;
    control  = OP_ADD;
    wait_done("mul_hold");
    in_valid = 1'b0;

    // Backpressure: three DONE cycles with out_ready low, then release.
    wait_ready("bp");
    out_ready = 1'b0;
    send("bp_add",     OP_ADD, 4'b0101, 4'b0110, 4'b1011, 4'b0101, 1);
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready_low", in_ready, 1'b0);
      check("bp_out_valid_held", out_valid, 1'b1);
      if (i < 2) step();
    end
    out_ready = 1'b1;
    step();
    check("bp_release_in_ready", in_ready, 1'b1);
    check("bp_release_out_valid", out_valid, 1'b0);

    // Reset in the second BUSY cycle of a multiply discards it.
    wait_ready("rst_mul");
    in_valid = 1'b1;
    A        = 4'b0101;
    B        = 4'b0011;
    control  = OP_MUL;
    step();
    in_valid = 1'b0;
    check("rst_mul_accepted", in_ready, 1'b0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mul_in_ready", in_ready, 1'b1);
    check("rst_mul_out_valid", out_valid, 1'b0);
    check("rst_mul_zero", zero, 1'b1);
    check("rst_mul_result", result, 4'b0000);
    for (int i = 0; i < 6; i++) begin
      step();
      check("rst_mul_no_valid", out_valid, 1'b0);
    end
    send("and_after_rst", OP_AND, 4'b1100, 4'b1010, 4'b1000, 4'b0100, 1);

    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    check("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
